lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store controller in the MEM stage. It is the initiator side of the data memory port. It accepts one load or store from the pipeline at a time, in byte, half, word or double size. Sub-word stores become a read-modify-write on the 64-bit word-addressed data memory. Misaligned, out-of-range and ROM-region writes are trapped before any memory access. The memory would otherwise drop ROM writes silently.

## Interface
- mem_size, 256: data memory depth in 64-bit words.
- rom_size, 2: number of read-only words at word addresses 0..rom_size-1.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; high when state is IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  zero-extend a load; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid only with resp_valid.
- mem_addr  out  32  byte address to memory, always 8-byte aligned.
- mem_wr_data  out  64  full word to write.
- mem_wr_enable  out  1  write strobe.
- mem_rd_enable  out  1  read strobe.
- mem_rd_data  in  64  combinational read data from memory.

## Operation
- FSM states and the requests that use them:
  - IDLE: waiting for a request.
  - LOAD: any load.
  - WRITE: double store.
  - RMW_RD then RMW_WR: byte, half or word store.
  - RESP: response cycle, then back to IDLE.
- Acceptance:
  - A request is accepted when req_valid and req_ready are both high at a rising edge.
  - On acceptance, addr, size, we, unsigned and wdata are latched.
- Fault check runs at acceptance. A fault is any one of:
  - misaligned: addr mod 2^size ≠ 0;
  - out of range: addr[31:3] ≥ mem_size;
  - ROM write: req_we=1 and addr[31:3] < rom_size.
- A faulting request goes IDLE→RESP with resp_fault=1 and makes no memory access.
- Lane select:
  - off = addr[2:0], little-endian.
  - Byte lane i is bits 8i+7:8i.
  - mem_addr = {addr[31:3], 3'b000}.
- Loads:
  - In LOAD, mem_rd_enable=1.
  - The controller captures (mem_rd_data >> 8·off), truncated to the access size.
  - The result is sign- or zero-extended to 64 bits.
- Double store: in WRITE, mem_wr_enable=1 and mem_wr_data=wdata.
- Sub-word store:
  - In RMW_RD, mem_rd_enable=1 and the word is captured.
  - In RMW_WR, mem_wr_data = (old & ~mask) | ((wdata << 8·off) & mask), with mask = (2^(8·2^size)−1) << 8·off. mem_wr_enable=1.
- mem_* outputs are decoded from state and latched registers. They are 0 in IDLE and RESP.
- Only one request is ever outstanding.
- Reset:
  - Assertion forces IDLE and clears all latched registers.
  - All outputs go to 0 immediately, except req_ready, which is 1 because the state is IDLE.
  - Reset during RMW_RD or RMW_WR, before the write edge, produces no memory write.

## Timing
- Cycle 0 is the acceptance edge. Response latency by request type:
  - Fault: resp_valid in cycle 1.
  - Load and double store: access in cycle 1, resp_valid in cycle 2.
  - Sub-word store: RMW_RD in cycle 1, RMW_WR in cycle 2, resp_valid in cycle 3.
- resp_valid is high for exactly one cycle. There is no resp_ready; the pipeline must consume the response.
- req_ready is low from cycle 1 until the cycle after RESP. A back-to-back request is accepted at the edge ending RESP+1.
- Memory writes commit at the edge that ends WRITE or RMW_WR.

## Structure
- lsu_pkg holds:
  - typedef enum lsu_size_e {SZ_B, SZ_H, SZ_W, SZ_D};
  - typedef enum lsu_state_e {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP}.
- Sub-module lsu_lane_align is purely combinational and provides:
  - load extract and extend: (word, off, size, unsigned) → data;
  - store merge: (old, wdata, off, size) → word.

## Test plan
- Load double: ROM[1]=0x15; load double at addr 0x8 → resp_valid at cycle 2, resp_rdata=0x15, fault=0.
- Sub-word store, then signed and unsigned loads:
  - Word 3 holds 0x1122334455667788. Store byte 0xAB at addr 0x1D.
  - mem_wr_data = 0x1122AB4455667788 with mem_wr_enable only in cycle 2; resp_valid at cycle 3.
  - Signed byte load at 0x1D → 0xFFFFFFFFFFFFFFAB.
  - Unsigned byte load at 0x1D → 0xAB.
- Faults:
  - Half load at 0x11 → fault at cycle 1, mem_rd_enable never high.
  - Double store at 0x8 (ROM) → fault, mem_wr_enable never high.
  - Load at addr 0x800 with mem_size=256 → fault.
- Reset mid-RMW: assert rst during RMW_RD of a word store to 0x20 → mem_wr_enable stays 0, word 4 unchanged, req_ready=1 after release.
- Back-to-back: hold req_valid high with a double store then a load to the same address → second accepted only after RESP, load returns the stored value.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store controller.
package lsu_pkg;

  localparam int unsigned MEM_SIZE_DEF = 256;
  localparam int unsigned ROM_SIZE_DEF = 2;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} lsu_state_e;

  function automatic logic [3:0] size_bytes(lsu_size_e s);
    return 4'd1 << s;
  endfunction

  function automatic logic is_misaligned(logic [31:0] a, lsu_size_e s);
    case (s)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      default: return |a[2:0];
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response bus and the 64-bit data memory port.
interface lsu_req_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;

  modport master (output valid, we, size, is_unsigned, addr, wdata,
                  input  ready, resp_valid, resp_rdata, resp_fault);
  modport slave  (input  valid, we, size, is_unsigned, addr, wdata,
                  output ready, resp_valid, resp_rdata, resp_fault);
endinterface

interface lsu_mem_if;
  logic [31:0] addr;
  logic [63:0] wr_data;
  logic        wr_enable;
  logic        rd_enable;
  logic [63:0] rd_data;

  modport master (output addr, wr_data, wr_enable, rd_enable, input rd_data);
  modport slave  (input  addr, wr_data, wr_enable, rd_enable, output rd_data);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_ld_word,
  input  logic [63:0] i_st_old,
  input  logic [63:0] i_st_wdata,
  input  logic [2:0]  i_off,
  input  lsu_size_e   i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_ld_data,
  output logic [63:0] o_st_word
);

  logic [5:0]  w_shamt;
  logic [63:0] w_shifted;
  logic [3:0]  w_lo;
  logic [3:0]  w_hi;
  logic [7:0]  w_lane_en;
  logic [63:0] w_mask;

  assign w_shamt   = {i_off, 3'b000};
  assign w_shifted = i_ld_word >> w_shamt;
  assign w_lo      = {1'b0, i_off};
  assign w_hi      = w_lo + size_bytes(i_size);

  always_comb begin
    o_ld_data = w_shifted;
    case (i_size)
      SZ_B: o_ld_data = i_unsigned ? {56'd0, w_shifted[7:0]}
                                   : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_ld_data = i_unsigned ? {48'd0, w_shifted[15:0]}
                                   : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W: o_ld_data = i_unsigned ? {32'd0, w_shifted[31:0]}
                                   : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

  // A lane is written when it falls inside [off, off + access bytes).
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign w_lane_en[gi]       = (4'(gi) >= w_lo) && (4'(gi) < w_hi);
    assign w_mask[8*gi +: 8]   = {8{w_lane_en[gi]}};
  end

  assign o_st_word = (i_st_old & ~w_mask) | ((i_st_wdata << w_shamt) & w_mask);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: one request at a time, RMW for sub-word stores, early fault trap.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter int unsigned ROM_SIZE = ROM_SIZE_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_next;
  logic [31:0] r_addr;
  lsu_size_e   r_size;
  logic        r_we;
  logic        r_unsigned;
  logic [63:0] r_wdata;
  logic [63:0] r_old;
  logic [63:0] r_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_word_idx;
  logic [63:0] w_ld_data;
  logic [63:0] w_merged;

  assign w_word_idx = {3'b000, req.addr[31:3]};
  assign w_accept   = req.valid && (r_state == IDLE);
  assign w_fault    = is_misaligned(req.addr, lsu_size_e'(req.size))
                   || (w_word_idx >= MEM_SIZE)
                   || (req.we && (w_word_idx < ROM_SIZE));

  lsu_lane_align u_align (
    .i_ld_word  (mem.rd_data),
    .i_st_old   (r_old),
    .i_st_wdata (r_wdata),
    .i_off      (r_addr[2:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ld_data  (w_ld_data),
    .o_st_word  (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    req.ready      = 1'b0;
    req.resp_valid = 1'b0;
    req.resp_rdata = 64'd0;
    req.resp_fault = 1'b0;
    mem.addr       = 32'd0;
    mem.wr_data    = 64'd0;
    mem.wr_enable  = 1'b0;
    mem.rd_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        req.ready = 1'b1;
        if (req.valid) begin
          if (w_fault)                         w_state_next = RESP;
          else if (!req.we)                    w_state_next = LOAD;
          else if (lsu_size_e'(req.size) == SZ_D) w_state_next = WRITE;
          else                                 w_state_next = RMW_RD;
        end
      end
      LOAD: begin
        mem.addr      = {r_addr[31:3], 3'b000};
        mem.rd_enable = 1'b1;
        w_state_next  = RESP;
      end
      WRITE: begin
        mem.addr      = {r_addr[31:3], 3'b000};
        mem.wr_enable = 1'b1;
        mem.wr_data   = r_wdata;
        w_state_next  = RESP;
      end
      RMW_RD: begin
        mem.addr      = {r_addr[31:3], 3'b000};
        mem.rd_enable = 1'b1;
        w_state_next  = RMW_WR;
      end
      RMW_WR: begin
        mem.addr      = {r_addr[31:3], 3'b000};
        mem.wr_enable = 1'b1;
        mem.wr_data   = w_merged;
        w_state_next  = RESP;
      end
      RESP: begin
        req.resp_valid = 1'b1;
        req.resp_rdata = r_rdata;
        req.resp_fault = r_fault;
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // r_rdata stays zero for stores and faults; only LOAD overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= 32'd0;
      r_size     <= SZ_B;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= 64'd0;
      r_old      <= 64'd0;
      r_rdata    <= 64'd0;
      r_fault    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req.addr;
        r_size     <= lsu_size_e'(req.size);
        r_we       <= req.we;
        r_unsigned <= req.is_unsigned;
        r_wdata    <= req.wdata;
        r_rdata    <= 64'd0;
        r_fault    <= w_fault;
      end
      if (r_state == LOAD)   r_rdata <= w_ld_data;
      if (r_state == RMW_RD) r_old   <= mem.rd_data;
    end
  end

endmodule
